mem_arbiter: RTL and testbench

- Two-to-one arbiter sharing the single external memory port between instruction fetch (imem) and the execute stage load/store path (dmem).
- Sits between the fetch/execute stages and the memory bus.
- Each requester keeps the existing mem valid/ready protocol and sees a private port.
- Registers the granted request, forwards it to memory, and steers the response and ready back to the winner.

---
 rtl/mem_arbiter_pkg.sv | 38 +++
 rtl/mem_arbiter_if.sv | 53 +++++
 rtl/mem_arbiter.sv | 106 ++++++++++
 tb/tb_mem_arbiter.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg
//   Shared types and constants for the two-to-one memory arbiter.
//   arbiter_state_type    : FSM states (IDLE, BUSY_I, BUSY_D)
//   mem_arbiter_reg_type  : complete registered state of the arbiter
//   init_mem_arbiter_reg  : reset value of that state
//   Optional feature macro: MEM_ARBITER_ROUND_ROBIN_EN (uses last_grant).
package mem_arbiter_pkg;

   localparam int ARB_XLEN = 32;   // address/data width of the registered fields
   localparam int CNT_W    = 10;   // timeout counter width

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      BUSY_I = 2'd1,
      BUSY_D = 2'd2
   } arbiter_state_type;

   typedef struct packed {
      arbiter_state_type   state;
      logic [ARB_XLEN-1:0] addr;
      logic [ARB_XLEN-1:0] wdata;
      logic [3:0]          wstrb;
      logic                instr;
      logic [CNT_W-1:0]    count;
      logic                last_grant;  // 1 = fetch granted last
   } mem_arbiter_reg_type;

   localparam mem_arbiter_reg_type init_mem_arbiter_reg = '{
      state:      IDLE,
      addr:       '0,
      wdata:      '0,
      wstrb:      4'h0,
      instr:      1'b0,
      count:      '0,
      last_grant: 1'b1
   };

endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if
//   Bundles the fetch port (imem_*), the load/store port (dmem_*) and the
//   external memory port (mem_*) of the arbiter.
//   Handshake: a requester raises x_valid with stable fields and holds them
//   until x_ready; x_ready is a single-cycle pulse carrying x_rdata/x_error.
//   The arbiter holds mem_valid and the mem_* fields stable until the memory
//   returns a single-cycle mem_ready pulse together with mem_rdata.
//   modport slave  : arbiter view
//   modport master : environment view (requesters + memory)
interface mem_arbiter_if #(
   parameter int XLEN = 32
);
   logic            imem_valid;
   logic [XLEN-1:0] imem_addr;
   logic            imem_ready;
   logic [XLEN-1:0] imem_rdata;
   logic            imem_error;

   logic            dmem_valid;
   logic [XLEN-1:0] dmem_addr;
   logic [XLEN-1:0] dmem_wdata;
   logic [3:0]      dmem_wstrb;
   logic            dmem_ready;
   logic [XLEN-1:0] dmem_rdata;
   logic            dmem_error;

   logic            mem_valid;
   logic            mem_instr;
   logic [XLEN-1:0] mem_addr;
   logic [XLEN-1:0] mem_wdata;
   logic [3:0]      mem_wstrb;
   logic            mem_ready;
   logic [XLEN-1:0] mem_rdata;

   modport slave (
      input  imem_valid, imem_addr,
      output imem_ready, imem_rdata, imem_error,
      input  dmem_valid, dmem_addr, dmem_wdata, dmem_wstrb,
      output dmem_ready, dmem_rdata, dmem_error,
      output mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
      input  mem_ready, mem_rdata
   );

   modport master (
      output imem_valid, imem_addr,
      input  imem_ready, imem_rdata, imem_error,
      output dmem_valid, dmem_addr, dmem_wdata, dmem_wstrb,
      input  dmem_ready, dmem_rdata, dmem_error,
      input  mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
      output mem_ready, mem_rdata
   );

endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Shares one memory port between instruction fetch and the load/store path.
//   The winning request is registered in IDLE, presented on mem_* while BUSY,
//   and the memory response is steered back to the winner as a ready pulse.
//   A transfer that sees no mem_ready is abandoned with an error response.
//   Ports:
//     clk     : clock
//     rst     : synchronous active-low reset
//     bus     : mem_arbiter_if.slave (imem_*, dmem_*, mem_* signals)
//     state_o : current FSM state (debug)
//   Parameters: XLEN (must equal ARB_XLEN), TIMEOUT (abandon threshold).
//   Optional feature macro: MEM_ARBITER_ROUND_ROBIN_EN -- alternate the
//   winner on simultaneous requests instead of fixed dmem priority.
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int XLEN    = ARB_XLEN,
   parameter int TIMEOUT = 1023
) (
   input  logic              clk,
   input  logic              rst,
   mem_arbiter_if.slave      bus,
   output arbiter_state_type state_o
);

   localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

   mem_arbiter_reg_type r_q, r_d;

   logic busy_i, busy_d;
   logic timeout, done;
   logic pick_d;

   assign busy_i  = (r_q.state == BUSY_I);
   assign busy_d  = (r_q.state == BUSY_D);
   // The counter is cleared at grant and advances once per busy cycle, so it
   // equals TIMEOUT after TIMEOUT busy cycles have elapsed.
   assign timeout = (r_q.count == TIMEOUT_C);
   // mem_ready wins over timeout: an error is only reported without mem_ready.
   assign done    = bus.mem_ready | timeout;

   always_comb begin
      r_d    = r_q;
      pick_d = 1'b0;
      case (r_q.state)
         IDLE: begin
            if (bus.dmem_valid || bus.imem_valid) begin
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
               // dmem wins a tie only when fetch was granted last time.
               pick_d = bus.dmem_valid & (~bus.imem_valid | r_q.last_grant);
               r_d.last_grant = ~pick_d;
`else
               pick_d = bus.dmem_valid;
`endif
               r_d.count = '0;
               if (pick_d) begin
                  r_d.state = BUSY_D;
                  r_d.addr  = bus.dmem_addr;
                  r_d.wdata = bus.dmem_wdata;
                  r_d.wstrb = bus.dmem_wstrb;
                  r_d.instr = 1'b0;
               end else begin
                  r_d.state = BUSY_I;
                  r_d.addr  = bus.imem_addr;
                  r_d.wdata = '0;
                  r_d.wstrb = 4'h0;
                  r_d.instr = 1'b1;
               end
            end
         end
         BUSY_I, BUSY_D: begin
            r_d.count = r_q.count + 1'b1;
            if (done) begin
               r_d.state = IDLE;
            end
         end
         default: r_d.state = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_q <= init_mem_arbiter_reg;
      end else begin
         r_q <= r_d;
      end
   end

   // Ready is suppressed while reset is asserted so an aborted transfer never
   // acknowledges its requester.
   assign bus.imem_ready = rst & busy_i & done;
   assign bus.dmem_ready = rst & busy_d & done;
   assign bus.imem_rdata = (bus.imem_ready & bus.mem_ready) ? bus.mem_rdata : '0;
   assign bus.dmem_rdata = (bus.dmem_ready & bus.mem_ready) ? bus.mem_rdata : '0;
   assign bus.imem_error = bus.imem_ready & ~bus.mem_ready;
   assign bus.dmem_error = bus.dmem_ready & ~bus.mem_ready;

   assign bus.mem_valid = (r_q.state != IDLE);
   assign bus.mem_instr = r_q.instr;
   assign bus.mem_addr  = r_q.addr;
   assign bus.mem_wdata = r_q.wdata;
   assign bus.mem_wstrb = r_q.wstrb;

   assign state_o = r_q.state;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
//   Directed bench for mem_arbiter with TIMEOUT = 8. Inputs are driven 2 ns
//   after the rising edge; outputs are checked 1 ns after drive.
//   Honours MEM_ARBITER_ROUND_ROBIN_EN for the simultaneous-request sequence.
module tb_mem_arbiter;
   import mem_arbiter_pkg::*;

   logic              clk = 1'b0;
   logic              rst;
   arbiter_state_type state;

   int n_assert = 0;
   int n_fail   = 0;

   logic [31:0] exp_q[$];
   logic [31:0] exp_v;

   mem_arbiter_if #(.XLEN(32)) bus ();

   mem_arbiter #(.XLEN(32), .TIMEOUT(8)) dut (
      .clk     (clk),
      .rst     (rst),
      .bus     (bus),
      .state_o (state)
   );

   always #5 clk = ~clk;

   task automatic cyc();
      @(posedge clk);
      #2;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   // Called in the first busy cycle: check the presented request, answer it
   // with zero wait, and check the steered response.
   task automatic serve(input string tag, input logic instr, input logic [31:0] addr,
                        input logic [3:0] strb, input logic [31:0] rd);
      chk({tag, "_mem_valid"}, 32'(bus.mem_valid), 32'd1);
      chk({tag, "_mem_instr"}, 32'(bus.mem_instr), 32'(instr));
      chk({tag, "_mem_addr"},  bus.mem_addr, addr);
      chk({tag, "_mem_wstrb"}, 32'(bus.mem_wstrb), 32'(strb));
      bus.mem_ready = 1'b1;
      bus.mem_rdata = rd;
      #1;
      if (instr) begin
         chk({tag, "_imem_ready"}, 32'(bus.imem_ready), 32'd1);
         chk({tag, "_imem_rdata"}, bus.imem_rdata, rd);
         chk({tag, "_imem_error"}, 32'(bus.imem_error), 32'd0);
         chk({tag, "_dmem_ready"}, 32'(bus.dmem_ready), 32'd0);
      end else begin
         chk({tag, "_dmem_ready"}, 32'(bus.dmem_ready), 32'd1);
         chk({tag, "_dmem_rdata"}, bus.dmem_rdata, rd);
         chk({tag, "_dmem_error"}, 32'(bus.dmem_error), 32'd0);
         chk({tag, "_imem_ready"}, 32'(bus.imem_ready), 32'd0);
      end
   endtask

   initial begin
      // ---------------- reset ----------------
      rst = 1'b0;
      bus.imem_valid = 1'b0; bus.imem_addr = '0;
      bus.dmem_valid = 1'b0; bus.dmem_addr = '0; bus.dmem_wdata = '0; bus.dmem_wstrb = '0;
      bus.mem_ready  = 1'b0; bus.mem_rdata = '0;
      cyc(); cyc();
      chk("rst_mem_valid", 32'(bus.mem_valid), 32'd0);
      chk("rst_mem_addr",  bus.mem_addr, 32'd0);
      chk("rst_mem_wdata", bus.mem_wdata, 32'd0);
      chk("rst_mem_wstrb", 32'(bus.mem_wstrb), 32'd0);
      chk("rst_mem_instr", 32'(bus.mem_instr), 32'd0);
      chk("rst_imem_ready", 32'(bus.imem_ready), 32'd0);
      chk("rst_dmem_ready", 32'(bus.dmem_ready), 32'd0);
      chk("rst_state", 32'(state), 32'(IDLE));
      rst = 1'b1;
      cyc();

      // ---------------- single fetch, 3-cycle memory ----------------
      bus.imem_valid = 1'b1; bus.imem_addr = 32'h0000_0100;
      cyc();
      chk("f1_state", 32'(state), 32'(BUSY_I));
      chk("f1_mem_valid", 32'(bus.mem_valid), 32'd1);
      chk("f1_mem_instr", 32'(bus.mem_instr), 32'd1);
      chk("f1_mem_addr",  bus.mem_addr, 32'h0000_0100);
      chk("f1_mem_wstrb", 32'(bus.mem_wstrb), 32'd0);
      for (int i = 0; i < 2; i++) begin
         cyc();
         chk("f1_wait_imem_ready", 32'(bus.imem_ready), 32'd0);
         chk("f1_wait_mem_valid", 32'(bus.mem_valid), 32'd1);
      end
      cyc();
      bus.mem_ready = 1'b1; bus.mem_rdata = 32'h0000_0013;
      #1;
      chk("f1_imem_ready", 32'(bus.imem_ready), 32'd1);
      chk("f1_imem_rdata", bus.imem_rdata, 32'h0000_0013);
      chk("f1_imem_error", 32'(bus.imem_error), 32'd0);
      chk("f1_dmem_ready", 32'(bus.dmem_ready), 32'd0);
      bus.imem_valid = 1'b0;
      cyc();
      bus.mem_ready = 1'b0;
      #1;
      chk("f1_after_mem_valid", 32'(bus.mem_valid), 32'd0);
      chk("f1_after_imem_ready", 32'(bus.imem_ready), 32'd0);
      chk("f1_after_imem_rdata", bus.imem_rdata, 32'd0);

      // ---------------- simultaneous requests ----------------
      bus.imem_valid = 1'b1; bus.imem_addr = 32'h0000_0200;
      bus.dmem_valid = 1'b1; bus.dmem_addr = 32'h0000_1000;
      bus.dmem_wdata = 32'hDEAD_BEEF; bus.dmem_wstrb = 4'hF;
      cyc();
      chk("sim_store_wdata", bus.mem_wdata, 32'hDEAD_BEEF);
      serve("sim_store", 1'b0, 32'h0000_1000, 4'hF, 32'h0000_0000);
      // dmem immediately issues a load while fetch is still waiting
      bus.dmem_addr = 32'h0000_1004; bus.dmem_wdata = '0; bus.dmem_wstrb = 4'h0;
      cyc();
      bus.mem_ready = 1'b0;
      #1;
      chk("sim_gap_mem_valid", 32'(bus.mem_valid), 32'd0);
      cyc();
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
      serve("sim_rr_fetch", 1'b1, 32'h0000_0200, 4'h0, 32'h0000_0093);
      bus.imem_valid = 1'b0;
      cyc();
      bus.mem_ready = 1'b0;
      cyc();
      serve("sim_rr_load", 1'b0, 32'h0000_1004, 4'h0, 32'h0000_0055);
      bus.dmem_valid = 1'b0;
`else
      serve("sim_fix_load", 1'b0, 32'h0000_1004, 4'h0, 32'h0000_0055);
      bus.dmem_valid = 1'b0;
      cyc();
      bus.mem_ready = 1'b0;
      cyc();
      serve("sim_fix_fetch", 1'b1, 32'h0000_0200, 4'h0, 32'h0000_0093);
      bus.imem_valid = 1'b0;
`endif
      cyc();
      bus.mem_ready = 1'b0;

      // ---------------- back-to-back zero-wait loads ----------------
      bus.dmem_valid = 1'b1; bus.dmem_addr = 32'h0000_2000; bus.dmem_wstrb = 4'h0;
      for (int k = 0; k < 4; k++) begin
         cyc();
         chk("b2b_mem_valid", 32'(bus.mem_valid), 32'd1);
         chk("b2b_mem_addr", bus.mem_addr, 32'h0000_2000 + 32'(4 * k));
         bus.mem_ready = 1'b1;
         bus.mem_rdata = 32'hA000_0000 + 32'(k);
         exp_q.push_back(32'hA000_0000 + 32'(k));
         #1;
         exp_v = exp_q.pop_front();
         chk("b2b_dmem_ready", 32'(bus.dmem_ready), 32'd1);
         chk("b2b_dmem_rdata", bus.dmem_rdata, exp_v);
         if (k == 3) bus.dmem_valid = 1'b0;
         bus.dmem_addr = bus.dmem_addr + 32'd4;
         cyc();
         bus.mem_ready = 1'b0;
         #1;
         chk("b2b_gap_dmem_ready", 32'(bus.dmem_ready), 32'd0);
         chk("b2b_gap_mem_valid", 32'(bus.mem_valid), 32'd0);
      end

      // ---------------- timeout, then pending fetch ----------------
      bus.dmem_valid = 1'b1; bus.dmem_addr = 32'h0000_3000;
      bus.mem_rdata  = 32'hFFFF_FFFF;
      cyc();
      bus.imem_valid = 1'b1; bus.imem_addr = 32'h0000_0400;
      for (int i = 0; i < 8; i++) begin
         #1;
         chk("to_wait_dmem_ready", 32'(bus.dmem_ready), 32'd0);
         chk("to_wait_mem_valid", 32'(bus.mem_valid), 32'd1);
         cyc();
      end
      #1;
      chk("to_dmem_ready", 32'(bus.dmem_ready), 32'd1);
      chk("to_dmem_error", 32'(bus.dmem_error), 32'd1);
      chk("to_dmem_rdata", bus.dmem_rdata, 32'd0);
      chk("to_imem_ready", 32'(bus.imem_ready), 32'd0);
      bus.dmem_valid = 1'b0;
      cyc();
      #1;
      chk("to_after_mem_valid", 32'(bus.mem_valid), 32'd0);
      chk("to_after_dmem_error", 32'(bus.dmem_error), 32'd0);
      cyc();
      serve("to_fetch", 1'b1, 32'h0000_0400, 4'h0, 32'h0BAD_0002);
      bus.imem_valid = 1'b0;
      cyc();
      bus.mem_ready = 1'b0;

      // ---------------- timeout / ready collision ----------------
      bus.dmem_valid = 1'b1; bus.dmem_addr = 32'h0000_3100;
      cyc();
      for (int i = 0; i < 8; i++) begin
         cyc();
      end
      bus.mem_ready = 1'b1; bus.mem_rdata = 32'h1234_5678;
      #1;
      chk("col_dmem_ready", 32'(bus.dmem_ready), 32'd1);
      chk("col_dmem_error", 32'(bus.dmem_error), 32'd0);
      chk("col_dmem_rdata", bus.dmem_rdata, 32'h1234_5678);
      bus.dmem_valid = 1'b0;
      cyc();
      bus.mem_ready = 1'b0;
      #1;
      chk("col_after_state", 32'(state), 32'(IDLE));

      // ---------------- reset mid-transfer ----------------
      bus.dmem_valid = 1'b1; bus.dmem_addr = 32'h0000_5000;
      bus.dmem_wdata = 32'h5555_AAAA; bus.dmem_wstrb = 4'h3;
      cyc();
      chk("rm_state", 32'(state), 32'(BUSY_D));
      chk("rm_mem_valid", 32'(bus.mem_valid), 32'd1);
      rst = 1'b0;
      bus.dmem_valid = 1'b0;
      #1;
      chk("rm_during_dmem_ready", 32'(bus.dmem_ready), 32'd0);
      cyc();
      chk("rm_mem_valid_drop", 32'(bus.mem_valid), 32'd0);
      chk("rm_dmem_ready", 32'(bus.dmem_ready), 32'd0);
      chk("rm_mem_addr", bus.mem_addr, 32'd0);
      chk("rm_mem_wstrb", 32'(bus.mem_wstrb), 32'd0);
      rst = 1'b1;
      cyc();
      bus.imem_valid = 1'b1; bus.imem_addr = 32'h0000_0600;
      cyc();
      serve("rm_fetch", 1'b1, 32'h0000_0600, 4'h0, 32'h0000_6666);
      bus.imem_valid = 1'b0;
      cyc();
      bus.mem_ready = 1'b0;
      cyc();

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
